div: RTL



---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 24 ++
 rtl/div.sv | 102 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential arithmetic units: controller state encoding
// and default operand widths, common to mul and div.
package div_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WORK = 1'b1
    } state_t;

    localparam int DW_N_DEF = 16;
    localparam int DW_D_DEF = 8;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int DW_D = 8
) (
    input  logic [DW_D-1:0] p,
    input  logic            n_bit,
    input  logic [DW_D-1:0] b,
    output logic [DW_D-1:0] p_nxt,
    output logic            q_bit
);

    logic [DW_D:0]   t;
    logic [DW_D-1:0] diff;

    always_comb begin
        t     = {p, n_bit};
        // t < 2b, so the true difference is < b and fits the low DW_D bits
        diff  = t[DW_D-1:0] - b;
        q_bit = (t >= {1'b0, b});
        p_nxt = q_bit ? diff : t[DW_D-1:0];
    end

endmodule

// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with the
// same start/busy handshake as the shift-add multiplier.
module div
    import div_pkg::*;
#(
    parameter int DW_N = DW_N_DEF,
    parameter int DW_D = DW_D_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DW_N-1:0] a_bi,
    input  logic [DW_D-1:0] b_bi,
    input  logic            start_i,
    output logic            busy_o,
    output logic [DW_N-1:0] q_bo,
    output logic [DW_D-1:0] r_bo,
    output logic            err_o
);

    localparam int            CW       = $clog2(DW_N);
    localparam logic [CW-1:0] CTR_LAST = CW'(DW_N - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   ctr;
    logic [DW_N-1:0] n_reg;
    logic [DW_N-1:0] q_work;
    logic [DW_D-1:0] b_reg;
    logic [DW_D-1:0] p_reg;
    logic [DW_D-1:0] p_nxt;
    logic            q_bit;
    logic            last_step;

    div_step #(.DW_D(DW_D)) u_step (
        .p     (p_reg),
        .n_bit (n_reg[DW_N-1]),
        .b     (b_reg),
        .p_nxt (p_nxt),
        .q_bit (q_bit)
    );

    assign last_step = (ctr == CTR_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i)   state_nxt = ST_WORK;
            ST_WORK: if (last_step) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == ST_WORK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr    <= '0;
            n_reg  <= '0;
            q_work <= '0;
            b_reg  <= '0;
            p_reg  <= '0;
            q_bo   <= '0;
            r_bo   <= '0;
            err_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        n_reg  <= a_bi;
                        b_reg  <= b_bi;
                        p_reg  <= '0;
                        q_work <= '0;
                        ctr    <= '0;
                    end
                end
                ST_WORK: begin
                    n_reg  <= n_reg << 1;
                    p_reg  <= p_nxt;
                    q_work <= {q_work[DW_N-2:0], q_bit};
                    ctr    <= ctr + CW'(1);
                    // A zero divisor naturally yields all-ones quotient and a[DW_D-1:0] remainder
                    if (last_step) begin
                        q_bo  <= {q_work[DW_N-2:0], q_bit};
                        r_bo  <= p_nxt;
                        err_o <= (b_reg == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
